// File: rtl/readout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : readout_pkg                                            |
// | Description : Shared types, constants and group-search helper for    |
// |               the sample-memory readout sequencer.                   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package readout_pkg;

   localparam int GRP_CNT = 4;
   localparam int GRP_W   = 8;
   localparam int IDX_W   = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_NEXT = 3'd4,
      S_DONE = 3'd5
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } grp_next_t;

   // Lowest enabled group strictly above idx (or at idx when incl is set).
   // vld is low when no such group exists.
   function automatic grp_next_t next_grp(input logic [GRP_CNT-1:0] en,
                                          input logic [IDX_W-1:0]   idx,
                                          input logic               incl);
      grp_next_t res;
      res.vld = 1'b0;
      res.idx = '0;
      for (int k = GRP_CNT - 1; k >= 0; k--) begin
         if (en[k] && ((k > int'(idx)) || (incl && (k == int'(idx))))) begin
            res.vld = 1'b1;
            res.idx = k[IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/readout_ctrl_grp_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grp_sel                                                |
// | Description : Combinational priority encoder picking the next        |
// |               enabled channel group for byte serialisation.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module grp_sel
   import readout_pkg::*;
(
   input  logic [GRP_CNT-1:0] i_en,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic               i_first,
   output logic [IDX_W-1:0]   o_nxt,
   output logic               o_vld
);

   grp_next_t w_res;

   // With i_first set the search includes i_idx itself (used to find the
   // lowest enabled group from zero); otherwise it looks strictly above.
   always_comb begin
      w_res = next_grp(i_en, i_idx, i_first);
   end

   assign o_nxt = w_res.idx;
   assign o_vld = w_res.vld;

endmodule
`default_nettype wire

// File: rtl/readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : readout_ctrl                                           |
// | Description : Walks sample memory backwards from the newest sample   |
// |               and streams enabled byte groups to the transmitter.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module readout_ctrl
   import readout_pkg::*;
#(
   parameter int DEPTH_W  = 12,
   parameter int SAMPLE_W = 32
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [DEPTH_W-1:0]  end_addr_i,
   input  logic [DEPTH_W:0]    cnt_i,
   input  logic [GRP_CNT-1:0]  grp_en_i,
   output logic                mem_rd_o,
   output logic [DEPTH_W-1:0]  mem_addr_o,
   input  logic [SAMPLE_W-1:0] mem_i,
   output logic [GRP_W-1:0]    tx_o,
   output logic                tx_stb_o,
   input  logic                tx_rdy_i,
   output logic                busy_o,
   output logic                done_o
);

   localparam logic [DEPTH_W:0]   C_REM_ONE  = 1;
   localparam logic [DEPTH_W-1:0] C_ADDR_ONE = 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DEPTH_W-1:0]   r_addr;
   logic [DEPTH_W:0]     r_rem;
   logic [DEPTH_W:0]     w_rem_dec;
   logic [GRP_CNT-1:0]   r_en;
   logic [SAMPLE_W-1:0]  r_sample;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_sel;
   logic [IDX_W-1:0]     w_nidx;
   logic                 w_nvld;
   logic                 w_first;
   logic                 w_xfer;
   logic                 w_start_ok;

   assign w_first    = (r_state == S_WAIT);
   assign w_idx_sel  = w_first ? '0 : r_idx;
   assign w_xfer     = (r_state == S_SEND) && tx_rdy_i;
   assign w_rem_dec  = r_rem - C_REM_ONE;
   assign w_start_ok = (r_state == S_IDLE) && start_i && !abort_i;

   grp_sel u_grp_sel (
      .i_en    (r_en),
      .i_idx   (w_idx_sel),
      .i_first (w_first),
      .o_nxt   (w_nidx),
      .o_vld   (w_nvld)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; abort overrides everything including a start.
   always_comb begin
      w_state_nxt = r_state;
      if (abort_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (start_i) w_state_nxt = ((cnt_i == '0) || (grp_en_i == '0)) ? S_DONE : S_READ;
            S_READ: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_SEND;
            S_SEND: if (w_xfer && !w_nvld) w_state_nxt = S_NEXT;
            S_NEXT: w_state_nxt = (w_rem_dec == '0) ? S_DONE : S_READ;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath: request latch, sample capture, byte index and counters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr   <= '0;
         r_rem    <= '0;
         r_en     <= '0;
         r_sample <= '0;
         r_idx    <= '0;
      end else if (!abort_i) begin
         if (w_start_ok) begin
            r_addr <= end_addr_i;
            r_rem  <= cnt_i;
            r_en   <= grp_en_i;
         end
         if (r_state == S_WAIT) begin
            r_sample <= mem_i;
            r_idx    <= w_nidx;
         end
         if (w_xfer && w_nvld) begin
            r_idx <= w_nidx;
         end
         if (r_state == S_NEXT) begin
            r_rem  <= w_rem_dec;
            r_addr <= r_addr - C_ADDR_ONE;
         end
      end
   end

   assign mem_rd_o   = (r_state == S_READ);
   assign mem_addr_o = r_addr;
   assign tx_stb_o   = (r_state == S_SEND);
   assign tx_o       = (r_state == S_SEND) ? r_sample[r_idx*GRP_W +: GRP_W] : '0;
   assign busy_o     = (r_state != S_IDLE);
   assign done_o     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_readout_ctrl                                        |
// | Description : Self-checking bench for readout_ctrl with a queue-based|
// |               reference of expected addresses and bytes.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_readout_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        abort_i;
   logic [11:0] end_addr_i;
   logic [12:0] cnt_i;
   logic [3:0]  grp_en_i;
   logic        mem_rd_o;
   logic [11:0] mem_addr_o;
   logic [31:0] mem_i;
   logic [7:0]  tx_o;
   logic        tx_stb_o;
   logic        tx_rdy_i;
   logic        busy_o;
   logic        done_o;

   logic [31:0] mem [0:4095];
   logic [7:0]  exp_b[$];
   logic [11:0] exp_a[$];
   logic [7:0]  rx_q[$];
   logic [11:0] ra_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          hold_prev = 1'b0;
   logic [7:0]  prev_byte = 8'h00;

   readout_ctrl #(.DEPTH_W(12), .SAMPLE_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .end_addr_i(end_addr_i), .cnt_i(cnt_i), .grp_en_i(grp_en_i),
      .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_i(mem_i),
      .tx_o(tx_o), .tx_stb_o(tx_stb_o), .tx_rdy_i(tx_rdy_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous memory: data appears one cycle after the read strobe.
   always @(posedge clk_i) if (mem_rd_o) mem_i <= mem[mem_addr_o];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: newest sample first, addresses modulo 4096, enabled bytes LSB first.
   task automatic build_model(input logic [11:0] ea, input logic [12:0] c, input logic [3:0] en);
      logic [11:0] a;
      exp_b.delete();
      exp_a.delete();
      if (en != 4'h0) begin
         for (int s = 0; s < int'(c); s++) begin
            a = 12'(((int'(ea) - (s % 4096)) + 4096) % 4096);
            exp_a.push_back(a);
            for (int k = 0; k < 4; k++)
               if (en[k]) exp_b.push_back(mem[a][8*k +: 8]);
         end
      end
   endtask

   // Per-cycle compare of reads, transfers and handshake stability.
   always @(negedge clk_i) begin
      if (rst_i) begin
         hold_prev = 1'b0;
      end else begin
         if (mem_rd_o) begin
            ra_q.push_back(mem_addr_o);
            if (exp_a.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_read: got addr %0h expected none", mem_addr_o);
            end else check("rd_addr", 32'(mem_addr_o), 32'(exp_a.pop_front()));
         end
         if (hold_prev) begin
            check("hold_stb", 32'(tx_stb_o), 32'd1);
            check("hold_byte", 32'(tx_o), 32'(prev_byte));
         end
         if (tx_stb_o && tx_rdy_i) begin
            rx_q.push_back(tx_o);
            if (exp_b.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_byte: got %0h expected none", tx_o);
            end else check("tx_byte", 32'(tx_o), 32'(exp_b.pop_front()));
         end
         hold_prev = tx_stb_o && !tx_rdy_i && !abort_i;
         prev_byte = tx_o;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_start(input logic [11:0] ea, input logic [12:0] c, input logic [3:0] en);
      build_model(ea, c, en);
      start_i = 1'b1; end_addr_i = ea; cnt_i = c; grp_en_i = en;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic run(input string nm, input logic [11:0] ea, input logic [12:0] c,
                      input logic [3:0] en, input int rmode, input int exp_lat, input bit inject);
      int edges, first, budget;
      bit dflag;
      rx_q.delete(); ra_q.delete();
      budget = 16 * int'(c) + 50;
      first = -1; dflag = 1'b0;
      tx_rdy_i = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      do_start(ea, c, en);
      edges = 1;
      while (!dflag && edges < budget) begin
         if (tx_stb_o && first < 0) first = edges;
         if (done_o) dflag = 1'b1;
         else begin
            start_i = inject && (edges == 2);
            if (start_i) begin
               end_addr_i = 12'd100; cnt_i = 13'd5; grp_en_i = 4'hF;
               check({nm, "_busy_at_start"}, 32'(busy_o), 32'd1);
            end
            tx_rdy_i = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk_i); #1;
            edges++;
         end
      end
      start_i = 1'b0;
      if (!dflag) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, edges);
      end else begin
         if (c == 0 || en == 0) begin
            check({nm, "_done_lat"}, 32'(edges), 32'd1);
            check({nm, "_no_stb"}, 32'(first), 32'hFFFF_FFFF);
            check({nm, "_no_rd"}, 32'(ra_q.size()), 32'd0);
         end
         @(posedge clk_i); #1;
         check({nm, "_done_pulse"}, 32'(done_o), 32'd0);
         check({nm, "_idle"}, 32'(busy_o), 32'd0);
      end
      check({nm, "_bytes_left"}, 32'(exp_b.size()), 32'd0);
      check({nm, "_addrs_left"}, 32'(exp_a.size()), 32'd0);
      if (exp_lat > 0) check({nm, "_first_stb_lat"}, 32'(first), 32'(exp_lat));
   endtask

   task automatic check_basic_bytes(input string nm);
      logic [7:0] lit [8];
      lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      check({nm, "_count"}, 32'(rx_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++)
         check($sformatf("%s_b%0d", nm, i), 32'(rx_q[i]), 32'(lit[i]));
   endtask

   initial begin
      int w, dcnt;
      logic [7:0]  skip_lit [4];
      logic [11:0] wrap_lit [3];
      logic [11:0] ign_lit  [3];
      skip_lit = '{8'h11, 8'h33, 8'h55, 8'h77};
      wrap_lit = '{12'd1, 12'd0, 12'd4095};
      ign_lit  = '{12'd10, 12'd9, 12'd8};

      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; end_addr_i = '0;
      cnt_i = '0; grp_en_i = '0; tx_rdy_i = 1'b1; mem_i = '0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      mem[5] = 32'h4433_2211;
      mem[4] = 32'h8877_6655;

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_mem_rd", 32'(mem_rd_o), 32'd0);
      check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
      check("rst_tx", 32'(tx_o), 32'd0);
      check("rst_stb", 32'(tx_stb_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      run("basic", 12'd5, 13'd2, 4'hF, 0, 3, 1'b0);
      check_basic_bytes("basic");

      run("skip", 12'd5, 13'd2, 4'b0101, 0, 3, 1'b0);
      check("skip_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         check($sformatf("skip_b%0d", i), 32'(rx_q[i]), 32'(skip_lit[i]));

      run("wrap", 12'd1, 13'd3, 4'hF, 1, 3, 1'b0);
      check("wrap_count", 32'(ra_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < ra_q.size(); i++)
         check($sformatf("wrap_a%0d", i), 32'(ra_q[i]), 32'(wrap_lit[i]));
      check("wrap_bytes", 32'(rx_q.size()), 32'd12);

      run("empty_cnt", 12'd7, 13'd0, 4'hF, 0, -1, 1'b0);
      run("empty_en", 12'd7, 13'd3, 4'h0, 0, -1, 1'b0);

      // Abort while the second byte is being offered.
      rx_q.delete(); ra_q.delete();
      tx_rdy_i = 1'b1;
      do_start(12'd5, 13'd2, 4'hF);
      w = 0;
      while (rx_q.size() < 1 && w < 20) begin @(posedge clk_i); #1; w++; end
      check("abort_pre_stb", 32'(tx_stb_o), 32'd1);
      check("abort_pre_byte", 32'(tx_o), 32'h22);
      tx_rdy_i = 1'b0; abort_i = 1'b1;
      exp_b.delete(); exp_a.delete();
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_stb", 32'(tx_stb_o), 32'd0);
      dcnt = 32'(done_o);
      repeat (3) begin @(posedge clk_i); #1; dcnt += 32'(done_o); end
      check("abort_no_done", 32'(dcnt), 32'd0);

      run("ignored", 12'd10, 13'd3, 4'b0001, 1, 3, 1'b1);
      check("ignored_count", 32'(ra_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < ra_q.size(); i++)
         check($sformatf("ignored_a%0d", i), 32'(ra_q[i]), 32'(ign_lit[i]));

      // Asynchronous reset between edges while sending.
      tx_rdy_i = 1'b1;
      do_start(12'd5, 13'd2, 4'hF);
      w = 0;
      while (!tx_stb_o && w < 20) begin @(posedge clk_i); #1; w++; end
      @(negedge clk_i); #2;
      rst_i = 1'b1;
      #1;
      check("arst_stb", 32'(tx_stb_o), 32'd0);
      check("arst_tx", 32'(tx_o), 32'd0);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_rd", 32'(mem_rd_o), 32'd0);
      check("arst_addr", 32'(mem_addr_o), 32'd0);
      check("arst_done", 32'(done_o), 32'd0);
      exp_b.delete(); exp_a.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      run("after_rst", 12'd5, 13'd2, 4'hF, 0, 3, 1'b0);
      check_basic_bytes("after_rst");

      for (int i = 0; i < 6; i++)
         run($sformatf("rand%0d", i), 12'($urandom_range(0, 4095)),
             13'($urandom_range(1, 6)), 4'($urandom_range(1, 15)), 1, 3, 1'b0);

      run("rewrap", 12'd5, 13'd4098, 4'b1000, 0, 3, 1'b0);
      check("rewrap_count", 32'(rx_q.size()), 32'd4098);
      if (ra_q.size() > 4096) check("rewrap_reread", 32'(ra_q[4096]), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
